// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Loads that hit are answered combinationally. Load misses and all stores
// stall the core while one request/acknowledge transaction runs on the
// backing-memory port.
//
// Handshake (backing memory): mem_req_o rises and then stays high, with
// mem_we_o, mem_addr_o and mem_wdata_o held stable, until the cycle in which
// mem_ack_i is 1. That is the single completion cycle: mem_rdata_i is valid in
// that cycle. The next cycle is always IDLE. mem_ack_i is ignored when no
// request is outstanding.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [CNT_WIDTH-1:0]  hit_count_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_MISS  = 2'd1,
    WRITE_THRU = 2'd2
  } state_t;

  // Current and next FSM state. Kept as plainly named signals so that
  // checkers can bind to them.
  state_t state;
  state_t state_next;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  load_hit_idle;
  logic                  load_miss_idle;
  logic                  fill_line;
  logic                  update_line;
  logic [CNT_WIDTH-1:0]  hit_count;
  logic [CNT_WIDTH-1:0]  miss_count;

  // The byte-offset bits never select anything in a one-word line.
  logic unused_byte_offset;
  assign unused_byte_offset = ^addr_i[1:0];

  assign index = addr_i[INDEX_BITS+1:2];
  assign tag   = addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit   = valid[index] && (tag_mem[index] == tag);

  assign load_hit_idle  = (state == IDLE) && req_i && !we_i && hit;
  assign load_miss_idle = (state == IDLE) && req_i && !we_i && !hit;

  // A reset in the completion cycle abandons the transaction, so the ack is
  // not allowed to fill or update anything.
  assign fill_line   = (state == READ_MISS) && mem_ack_i && !rst_i;
  assign update_line = (state == WRITE_THRU) && mem_ack_i && hit && !rst_i;

  assign hit_count_o  = hit_count;
  assign miss_count_o = miss_count;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, stall, load data and backing-memory port outputs.
  always_comb begin
    state_next  = state;
    stall_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    mem_wdata_o = '0;
    unique case (state)
      IDLE: begin
        if (req_i) begin
          if (we_i) begin
            stall_o    = 1'b1;
            state_next = WRITE_THRU;
          end else if (hit) begin
            rdata_o = data_mem[index];
          end else begin
            stall_o    = 1'b1;
            state_next = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          rdata_o    = mem_rdata_i;
          state_next = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      WRITE_THRU: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_wdata_o = wdata_i;
        if (mem_ack_i) begin
          state_next = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // The pipeline must never be frozen while reset is applied.
    if (rst_i) begin
      stall_o = 1'b0;
    end
  end

  // Valid bits: cleared by reset, set when a read miss fills a line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= '0;
    end else if (fill_line) begin
      valid[index] <= 1'b1;
    end
  end

  // Tag and data storage: written on a fill, data also on a store hit.
  always_ff @(posedge clk_i) begin
    if (fill_line) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= mem_rdata_i;
    end else if (update_line) begin
      data_mem[index] <= wdata_i;
    end
  end

  // Saturating load hit/miss counters; stores are not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit_idle && (hit_count != '1)) begin
        hit_count <= hit_count + CNT_WIDTH'(1);
      end
      if (load_miss_idle && (miss_count != '1)) begin
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
Direct-mapped, write-through, no-write-allocate data cache. It is the responder to the core's memory-stage load/store requests, and it sits between the memory pipeline stage and a slower backing data memory.
- Hits are answered combinationally in the same cycle.
- Misses and all stores raise stall_o, which feeds the hazard unit, while a request/acknowledge transaction runs on the backing-memory port.
- Hit and miss counters are provided for performance measurement.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 32, byte address width
INDEX_BITS, 3, log2 of line count (8 one-word lines); tag = addr_i[ADDR_WIDTH-1:INDEX_BITS+2]
CNT_WIDTH, 16, width of the hit and miss counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
req_i  in  1  core request valid (memory stage)
we_i  in  1  1 = store, 0 = load
addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
wdata_i  in  DATA_WIDTH  store data
rdata_o  out  DATA_WIDTH  load data
stall_o  out  1  freeze the pipeline; the core holds req_i, we_i, addr_i and wdata_i stable while this is 1
mem_req_o  out  1  backing-memory request
mem_we_o  out  1  backing-memory write enable
mem_addr_o  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
mem_wdata_o  out  DATA_WIDTH  backing-memory write data
mem_ack_i  in  1  backing memory done; mem_rdata_i valid in the same cycle
mem_rdata_i  in  DATA_WIDTH  backing-memory read data
hit_count_o  out  CNT_WIDTH  saturating count of load hits
miss_count_o  out  CNT_WIDTH  saturating count of load misses

Behaviour:
- Storage: per line, one valid bit, one tag and one data word, all in flip-flops. index = addr_i[INDEX_BITS+1:2]. hit = valid[index] & (tag[index] == addr tag).
- Reset (rst_i=1 at a clock edge):
  - all valid bits cleared; state goes to IDLE; counters go to 0.
  - mem_req_o and mem_we_o are 0 from the following cycle.
  - stall_o is forced to 0 while rst_i=1.
  - rdata_o is 0 when no request is in progress.
- Reset mid-transaction: the transaction is abandoned and no line is filled or updated. A mem_ack_i arriving in the reset cycle is ignored.
- FSM states: IDLE, READ_MISS, WRITE_THRU.
- IDLE:
  - req_i=0: no action; stall_o=0.
  - load hit: rdata_o = line data combinationally; stall_o=0; hit_count increments at the clock edge. Zero-cycle latency.
  - load miss: stall_o=1 in the same cycle; next state READ_MISS; miss_count increments.
  - store (hit or miss): stall_o=1; next state WRITE_THRU.
- READ_MISS:
  - Outputs: mem_req_o=1, mem_we_o=0, mem_addr_o = {addr_i[ADDR_WIDTH-1:2], 2'b00}.
  - Held until mem_ack_i. stall_o=1 while mem_ack_i=0.
  - In the ack cycle: stall_o=0 and rdata_o = mem_rdata_i (bypass). At the edge the line is filled (valid=1, tag, data) and the state returns to IDLE.
  - Load-miss latency = 1 + N cycles, where N is the number of cycles until ack.
- WRITE_THRU:
  - Outputs: mem_req_o=1, mem_we_o=1, mem_addr_o aligned as above, mem_wdata_o = wdata_i.
  - In the ack cycle: stall_o=0. At the edge, if the line hits it is updated with wdata_i; on a miss the line is untouched (no allocate). The state returns to IDLE.
- mem_req_o stays high, with address and data stable, until mem_ack_i. mem_ack_i is ignored in IDLE.
- After a completed transaction the next cycle is in IDLE, so back-to-back requests are legal.
- A load to the same index but a different tag replaces the line (conflict miss).
- Counters saturate at all-ones and never wrap. Stores are not counted.
- mem_wdata_o is 0 when not in WRITE_THRU.

Test Plan:
- Reset, then load 0x0000_0010 with backing memory holding 0xDEAD_BEEF and ack after 3 cycles:
  - stall_o high for 4 cycles, low in the ack cycle with rdata_o=0xDEAD_BEEF.
  - miss_count=1.
  - A repeat load hits with zero stall, rdata_o=0xDEAD_BEEF, hit_count=1.
- Store 0x1234_5678 to 0x10 (line cached):
  - mem_we_o=1, mem_addr_o=0x10 until ack.
  - A following load of 0x10 hits and returns 0x1234_5678 with no mem_req_o.
- Store to uncached 0x40, then load 0x40:
  - The store does not allocate, so the load misses (miss_count increments) and issues a read.
- Conflict: load 0x00 then 0x20 (same index 0, different tag):
  - Both miss; reloading 0x00 misses again.
- Assert rst_i during READ_MISS with ack arriving in the same cycle:
  - mem_req_o=0 next cycle; the line is not valid; counters are 0.
- Force 65535 hits then one more:
  - hit_count_o stays 0xFFFF.
